// File: rtl/croad_vehicle_detector.sv
`timescale 1ns/1ps
// croad_vehicle_detector
//
// Country-road vehicle detector for a highway/country-road traffic light.
// The raw loop sensor is synchronized and debounced; each debounced rising
// edge of vehicle presence is one arrival. While the controller shows GREEN
// to the country road and we are serving, one vehicle departs every
// DEPART_CYCLES cycles. A small FSM turns the queue into a registered
// request (car_on_croad) for the traffic controller.
//
// Optional feature: define CROAD_TIMEOUT_EN to build a starvation counter
// that raises the sticky wait_alarm after MAX_WAIT cycles spent in REQUEST.
// Without the macro no counter is built and wait_alarm is tied low.
//
// Ports:
//   clk           in   system clock, rising edge
//   clear         in   asynchronous active-high reset
//   loop_raw      in   raw asynchronous loop sensor, 1 = vehicle over loop
//   crd_sig       in   [1:0] country-road light: 0 RED, 1 YELLOW, 2 GREEN (3 = RED)
//   car_on_croad  out  registered request, 1 in REQUEST and SERVING
//   queue_count   out  [3:0] registered count of queued vehicles, saturates at 15
//   overflow      out  sticky, arrival seen while the queue was full
//   wait_alarm    out  sticky starvation flag (CROAD_TIMEOUT_EN only)
//   state_dbg     out  [1:0] FSM state for observation: 0 IDLE, 1 REQUEST, 2 SERVING
module croad_vehicle_detector #(
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int DEPART_CYCLES   = 4,
  parameter int MAX_WAIT        = 64
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       loop_raw,
  input  logic [1:0] crd_sig,
  output logic       car_on_croad,
  output logic [3:0] queue_count,
  output logic       overflow,
  output logic       wait_alarm,
  output logic [1:0] state_dbg
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int DP_W = (DEPART_CYCLES > 1) ? $clog2(DEPART_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DP_W-1:0] DP_LAST = DP_W'(DEPART_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVING = 2'd2
  } state_t;

  state_t          state;
  logic            sync1;
  logic            sync2;
  logic            presence;
  logic [DB_W-1:0] db_cnt;
  logic [DP_W-1:0] dep_timer;

  logic green;
  logic db_flip;
  logic arrival;
  logic dep_tick;
  logic departure;

  // Only GREEN counts as green; YELLOW and the unused code 3 behave like RED.
  assign green     = (crd_sig == 2'd2);
  // Presence flips on the DEBOUNCE_CYCLES-th consecutive disagreeing sample.
  assign db_flip   = (sync2 != presence) && (db_cnt == DB_LAST);
  assign arrival   = db_flip && !presence;
  assign dep_tick  = (state == SERVING) && green && (dep_timer == DP_LAST);
  // A timer tick with an empty queue has nobody to release.
  assign departure = dep_tick && (queue_count != 4'd0);
  assign state_dbg = state;

  // Two-flop synchronizer for the asynchronous loop sensor.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= loop_raw;
      sync2 <= sync1;
    end
  end

  // Debounce: any sample agreeing with the current presence restarts the run.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      presence <= 1'b0;
      db_cnt   <= '0;
    end else if (sync2 != presence) begin
      if (db_cnt == DB_LAST) begin
        presence <= sync2;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  // Queue counter. A simultaneous arrival and departure cancel out, so the
  // full-queue overflow flag is only raised by an unmatched arrival.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      queue_count <= 4'd0;
      overflow    <= 1'b0;
    end else if (arrival && !departure) begin
      if (queue_count == 4'd15) begin
        overflow <= 1'b1;
      end else begin
        queue_count <= queue_count + 4'd1;
      end
    end else if (departure && !arrival) begin
      queue_count <= queue_count - 4'd1;
    end
  end

  // Departure timer runs only while serving under GREEN.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      dep_timer <= '0;
    end else if ((state == SERVING) && green) begin
      dep_timer <= dep_tick ? '0 : dep_timer + 1'b1;
    end else begin
      dep_timer <= '0;
    end
  end

  // Request FSM; car_on_croad is registered alongside the next state.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state        <= IDLE;
      car_on_croad <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (queue_count != 4'd0) begin
            state        <= REQUEST;
            car_on_croad <= 1'b1;
          end
        end
        REQUEST: begin
          if (queue_count == 4'd0) begin
            state        <= IDLE;
            car_on_croad <= 1'b0;
          end else if (green) begin
            state <= SERVING;
          end
        end
        SERVING: begin
          if (queue_count == 4'd0) begin
            state        <= IDLE;
            car_on_croad <= 1'b0;
          end else if (!green) begin
            state <= REQUEST;
          end
        end
        default: begin
          state        <= IDLE;
          car_on_croad <= 1'b0;
        end
      endcase
    end
  end

`ifdef CROAD_TIMEOUT_EN
  localparam int WT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WT_W-1:0] WT_MAX  = WT_W'(MAX_WAIT);
  localparam logic [WT_W-1:0] WT_LAST = WT_W'(MAX_WAIT - 1);

  logic [WT_W-1:0] wait_cnt;

  // Counts cycles spent in REQUEST; leaving REQUEST restarts it. The counter
  // parks at MAX_WAIT so it cannot wrap while the alarm is held.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      wait_cnt   <= '0;
      wait_alarm <= 1'b0;
    end else if (state == REQUEST) begin
      if (wait_cnt != WT_MAX) begin
        wait_cnt <= wait_cnt + 1'b1;
        if (wait_cnt == WT_LAST) begin
          wait_alarm <= 1'b1;
        end
      end
    end else begin
      wait_cnt <= '0;
    end
  end
`else
  assign wait_alarm = 1'b0;
`endif

endmodule

// File: tb/tb_croad_vehicle_detector.sv
`timescale 1ns/1ps
// Testbench for croad_vehicle_detector: directed scenarios followed by a
// randomized phase, all compared every cycle against a behavioural model.
module tb_croad_vehicle_detector;

  localparam int DB = 3;
  localparam int DP = 4;
  localparam int MW = 64;
`ifdef CROAD_TIMEOUT_EN
  localparam bit ALARM_ON = 1'b1;
`else
  localparam bit ALARM_ON = 1'b0;
`endif

  // clock / reset
  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic       loop_raw = 1'b0;
  logic [1:0] crd_sig = 2'd0;
  logic       car_on_croad;
  logic [3:0] queue_count;
  logic       overflow;
  logic       wait_alarm;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  croad_vehicle_detector #(
    .DEBOUNCE_CYCLES(DB),
    .DEPART_CYCLES  (DP),
    .MAX_WAIT       (MW)
  ) dut (
    .clk         (clk),
    .clear       (clear),
    .loop_raw    (loop_raw),
    .crd_sig     (crd_sig),
    .car_on_croad(car_on_croad),
    .queue_count (queue_count),
    .overflow    (overflow),
    .wait_alarm  (wait_alarm),
    .state_dbg   (state_dbg)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Behavioural reference model.
  // raw_hist[0] is the loop value from the previous edge, raw_hist[1] from
  // two edges back: that is what the debouncer sees after synchronization.
  // Presence flips when the last DB seen samples all disagree with it.
  bit raw_hist[$];
  bit seen_hist[$];
  bit m_pres;
  int m_q;
  bit m_ovf;
  bit m_car;
  bit m_alarm;
  bit m_requesting;
  bit m_serving;
  int m_green_run;
  int m_req_run;

  function automatic void model_reset();
    raw_hist  = '{};
    seen_hist = '{};
    raw_hist.push_back(1'b0);
    raw_hist.push_back(1'b0);
    for (int i = 0; i < DB; i++) seen_hist.push_back(1'b0);
    m_pres = 0; m_q = 0; m_ovf = 0; m_car = 0; m_alarm = 0;
    m_requesting = 0; m_serving = 0; m_green_run = 0; m_req_run = 0;
  endfunction

  function automatic void model_edge();
    bit green, seen, flip, arr, tick, dep;
    int old_q;
    green = (crd_sig == 2'd2);
    old_q = m_q;
    seen = raw_hist[1];
    raw_hist.push_front(loop_raw);
    void'(raw_hist.pop_back());
    seen_hist.push_front(seen);
    void'(seen_hist.pop_back());
    flip = 1;
    foreach (seen_hist[i]) if (seen_hist[i] == m_pres) flip = 0;
    arr = flip && !m_pres;
    if (flip) m_pres = !m_pres;
    // one departure after every DP green cycles spent serving
    tick = m_serving && green && (m_green_run == DP - 1);
    dep  = tick && (old_q != 0);
    if (arr && !dep) begin
      if (old_q == 15) m_ovf = 1;
      else m_q = old_q + 1;
    end else if (dep && !arr) begin
      m_q = old_q - 1;
    end
    if (m_serving && green) m_green_run = tick ? 0 : m_green_run + 1;
    else m_green_run = 0;
    // starvation: consecutive cycles that began in the requesting state
    if (m_requesting) begin
      m_req_run++;
      if (m_req_run >= MW && ALARM_ON) m_alarm = 1;
    end else begin
      m_req_run = 0;
    end
    // request/serve decision from the queue length before this edge
    if (!m_requesting && !m_serving) begin
      if (old_q != 0) m_requesting = 1;
    end else if (old_q == 0) begin
      m_requesting = 0; m_serving = 0;
    end else if (m_requesting && green) begin
      m_requesting = 0; m_serving = 1;
    end else if (m_serving && !green) begin
      m_requesting = 1; m_serving = 0;
    end
    m_car = m_requesting || m_serving;
  endfunction

  // scoreboard
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_all();
    chk("car_on_croad", {7'd0, car_on_croad}, {7'd0, m_car});
    chk("queue_count", {4'd0, queue_count}, 8'(m_q));
    chk("overflow", {7'd0, overflow}, {7'd0, m_ovf});
    chk("wait_alarm", {7'd0, wait_alarm}, {7'd0, m_alarm});
  endtask

  // driver tasks: inputs change on the falling edge, outputs checked there too
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
    end
  endtask

  task automatic do_clear(input int n);
    clear = 1'b1;
    #1;
    model_reset();
    chk("async_clear_queue", {4'd0, queue_count}, 8'd0);
    chk("async_clear_car", {7'd0, car_on_croad}, 8'd0);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_reset();
      @(negedge clk);
      check_all();
    end
    clear = 1'b0;
  endtask

  task automatic arrive();
    loop_raw = 1'b1;
    step(DB + 2);
    loop_raw = 1'b0;
    step(DB + 2);
  endtask

  initial begin
    int seg_left;
    model_reset();
    @(negedge clk);
    step(0);
    @(posedge clk);
    @(negedge clk);
    chk("reset_queue", {4'd0, queue_count}, 8'd0);
    chk("reset_car", {7'd0, car_on_croad}, 8'd0);
    chk("reset_overflow", {7'd0, overflow}, 8'd0);
    chk("reset_alarm", {7'd0, wait_alarm}, 8'd0);

    // first arrival latency out of reset
    loop_raw = 1'b1;
    do_clear(5);
    step(DB + 2);
    chk("lat_queue_at5", {4'd0, queue_count}, 8'd1);
    chk("lat_car_at5", {7'd0, car_on_croad}, 8'd0);
    step(1);
    chk("lat_queue_at6", {4'd0, queue_count}, 8'd1);
    chk("lat_car_at6", {7'd0, car_on_croad}, 8'd1);

    // clear mid-operation with the loop still occupied: a fresh arrival
    do_clear(3);
    chk("clear_discards", {4'd0, queue_count}, 8'd0);
    step(DB + 3);
    chk("rearrival_after_clear", {4'd0, queue_count}, 8'd1);
    loop_raw = 1'b0;
    step(DB + 2);

    // short glitch is rejected
    do_clear(2);
    loop_raw = 1'b1;
    step(2);
    loop_raw = 1'b0;
    step(8);
    chk("glitch_queue", {4'd0, queue_count}, 8'd0);
    chk("glitch_car", {7'd0, car_on_croad}, 8'd0);

    // three arrivals drained under GREEN
    do_clear(2);
    repeat (3) arrive();
    chk("three_queued", {4'd0, queue_count}, 8'd3);
    crd_sig = 2'd2;
    step(1);
    chk("drain_start", {4'd0, queue_count}, 8'd3);
    step(DP);
    chk("drain_2", {4'd0, queue_count}, 8'd2);
    step(DP);
    chk("drain_1", {4'd0, queue_count}, 8'd1);
    step(DP);
    chk("drain_0", {4'd0, queue_count}, 8'd0);
    chk("drain_car_held", {7'd0, car_on_croad}, 8'd1);
    step(1);
    chk("drain_car_drop", {7'd0, car_on_croad}, 8'd0);

    // partial green, then yellow/red: back to requesting
    crd_sig = 2'd0;
    do_clear(2);
    repeat (2) arrive();
    crd_sig = 2'd2;
    step(6);
    crd_sig = 2'd1;
    step(1);
    crd_sig = 2'd0;
    step(2);
    chk("partial_green_queue", {4'd0, queue_count}, 8'd1);
    chk("partial_green_car", {7'd0, car_on_croad}, 8'd1);

    // full queue: coincident arrival/departure, then overflow
    do_clear(2);
    repeat (15) arrive();
    chk("full_queue", {4'd0, queue_count}, 8'd15);
    chk("full_no_overflow", {7'd0, overflow}, 8'd0);
    crd_sig  = 2'd2;
    loop_raw = 1'b1;
    step(DB + 2);
    chk("coincident_queue", {4'd0, queue_count}, 8'd15);
    chk("coincident_no_overflow", {7'd0, overflow}, 8'd0);
    crd_sig  = 2'd0;
    loop_raw = 1'b0;
    step(DB + 2);
    arrive();
    chk("overflow_queue", {4'd0, queue_count}, 8'd15);
    chk("overflow_set", {7'd0, overflow}, 8'd1);

    // long RED wait, RED encoded as 3 for half of it
    do_clear(2);
    arrive();
    crd_sig = 2'd3;
    step(MW / 2);
    crd_sig = 2'd0;
    step(MW / 2 + 2);
    chk("starved_car", {7'd0, car_on_croad}, 8'd1);
    chk("starved_alarm", {7'd0, wait_alarm}, {7'd0, ALARM_ON});

    // randomized phase
    do_clear(2);
    seg_left = 0;
    for (int i = 0; i < 2500; i++) begin
      if (seg_left == 0) begin
        loop_raw = 1'($urandom_range(0, 1));
        seg_left = $urandom_range(1, 8);
      end
      seg_left--;
      if ($urandom_range(0, 15) == 0) crd_sig = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 499) == 0) do_clear($urandom_range(1, 3));
      else step(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
